// File: rtl/io_bus_bridge_pkg.sv
// Shared decode constants, read-return selectors and FSM states for the CPU I/O bus bridge.
package io_bus_bridge_pkg;

    localparam logic [1:0]  IO_MASK      = 2'b11;
    localparam logic [17:0] IO_PORT_ADDR = 18'h30000;
    localparam logic [17:0] IO_CTRL_ADDR = 18'h30004;

    typedef enum logic [2:0] {
        RD_RAM  = 3'd0,
        RD_RX   = 3'd1,
        RD_CNT0 = 3'd2,
        RD_CNT1 = 3'd3,
        RD_CNT2 = 3'd4,
        RD_CNT3 = 3'd5,
        RD_ZERO = 3'd6
    } rd_sel_e;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HALT  = 2'd2
    } state_e;

    function automatic logic [7:0] snap_byte(input logic [31:0] snap, input logic [1:0] idx);
        return snap[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/io_bus_bridge_byte_fifo.sv
// Byte-wide synchronous FIFO with registered occupancy count; head byte is visible while non-empty.
module io_bus_bridge_byte_fifo
    import io_bus_bridge_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          i_push,
    input  logic [7:0]    i_din,
    input  logic          i_pop,
    output logic [7:0]    o_dout,
    output logic          o_full,
    output logic          o_empty,
    output logic [CW-1:0] o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    // A pop frees the slot in the same cycle, so a push at full still lands when paired with a pop.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk_in) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/io_bus_bridge.sv
// CPU memory-port bridge: RAM/I-O decode, one-cycle read return, UART TX FIFO and RX pop,
// free-running cycle counter with coherent snapshot, and RUN/DRAIN/HALT program-stop sequencing.
module io_bus_bridge
    import io_bus_bridge_pkg::*;
#(
    parameter int          TX_DEPTH    = 16,
    parameter int          FULL_MARGIN = 2,
    parameter logic [31:0] CNT_INIT    = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic [31:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_wr,
    output logic [7:0]  cpu_din,
    output logic        io_buffer_full,
    output logic [16:0] ram_a,
    output logic        ram_wr,
    output logic [7:0]  ram_dout,
    input  logic [7:0]  ram_din,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_pop,
    output logic        prog_end,
    output logic        tx_overflow
);

    localparam int            CW         = $clog2(TX_DEPTH) + 1;
    localparam logic [CW-1:0] FULL_LEVEL = CW'(TX_DEPTH - FULL_MARGIN);

    logic [17:0]   w_addr;
    logic          w_unused_addr;
    logic          w_io;
    logic          w_rd;
    logic          w_port_hit;
    logic          w_ctrl_blk;
    logic          w_ctrl_hit;
    rd_sel_e       w_rd_sel;
    state_e        w_state_nxt;
    logic          w_push;
    logic [7:0]    w_push_data;
    logic          w_pop_fire;
    logic          w_drop;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;

    rd_sel_e       r_rd_sel;
    logic          r_rd_vld;
    logic [31:0]   r_cnt;
    logic [31:0]   r_snap;
    logic [7:0]    r_rx_byte;
    logic          r_tx_overflow;
    state_e        r_state;

    assign w_addr        = cpu_a[17:0];
    assign w_unused_addr = ^cpu_a[31:18];
    assign w_io          = (w_addr[17:16] == IO_MASK);
    assign w_rd          = ~cpu_wr;
    assign w_port_hit    = (w_addr == IO_PORT_ADDR);
    assign w_ctrl_blk    = (w_addr[17:2] == IO_CTRL_ADDR[17:2]);
    assign w_ctrl_hit    = (w_addr == IO_CTRL_ADDR);

    assign ram_a    = cpu_a[16:0];
    assign ram_wr   = cpu_wr & ~w_io;
    assign ram_dout = cpu_dout;

    // Gated by reset so the UART never sees a consume while the bridge is held in reset.
    assign rx_pop = rst_in & w_rd & w_port_hit & rx_valid;

    always_comb begin
        w_rd_sel = RD_ZERO;
        if (w_rd) begin
            if (!w_io) begin
                w_rd_sel = RD_RAM;
            end else if (w_port_hit) begin
                w_rd_sel = RD_RX;
            end else if (w_ctrl_blk) begin
                case (w_addr[1:0])
                    2'd0:    w_rd_sel = RD_CNT0;
                    2'd1:    w_rd_sel = RD_CNT1;
                    2'd2:    w_rd_sel = RD_CNT2;
                    default: w_rd_sel = RD_CNT3;
                endcase
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_rd_sel      <= RD_RAM;
            r_rd_vld      <= 1'b0;
            r_cnt         <= CNT_INIT;
            r_snap        <= 32'h0000_0000;
            r_tx_overflow <= 1'b0;
        end else begin
            r_rd_sel <= w_rd_sel;
            r_rd_vld <= 1'b1;
            r_cnt    <= r_cnt + 32'd1;
            // Byte 0 read freezes the whole word so bytes 1..3 stay coherent while the counter runs.
            if (w_rd && w_ctrl_hit) begin
                r_snap <= r_cnt;
            end
            if (w_drop) begin
                r_tx_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_rd && w_port_hit) begin
            r_rx_byte <= rx_valid ? rx_data : 8'h00;
        end
    end

    always_comb begin
        cpu_din = 8'h00;
        if (r_rd_vld) begin
            case (r_rd_sel)
                RD_RAM:  cpu_din = ram_din;
                RD_RX:   cpu_din = r_rx_byte;
                RD_CNT0: cpu_din = snap_byte(r_snap, 2'd0);
                RD_CNT1: cpu_din = snap_byte(r_snap, 2'd1);
                RD_CNT2: cpu_din = snap_byte(r_snap, 2'd2);
                RD_CNT3: cpu_din = snap_byte(r_snap, 2'd3);
                default: cpu_din = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_push_data = cpu_dout;
        case (r_state)
            ST_RUN: begin
                if (cpu_wr && w_port_hit) begin
                    w_push = (cpu_dout != 8'h00);
                end else if (cpu_wr && w_ctrl_hit) begin
                    // The stop marker is a literal zero byte, which ordinary port writes can never enqueue.
                    w_push      = 1'b1;
                    w_push_data = 8'h00;
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_fifo_empty && !w_push) begin
                    w_state_nxt = ST_HALT;
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    assign w_pop_fire = tx_valid & tx_ready;
    assign w_drop     = w_push & w_fifo_full & ~w_pop_fire;

    io_bus_bridge_byte_fifo #(
        .DEPTH (TX_DEPTH),
        .CW    (CW)
    ) u_tx_fifo (
        .clk_in  (clk_in),
        .rst_in  (rst_in),
        .i_push  (w_push),
        .i_din   (w_push_data),
        .i_pop   (tx_ready),
        .o_dout  (tx_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign tx_valid       = ~w_fifo_empty;
    assign io_buffer_full = (w_fifo_count >= FULL_LEVEL);
    assign tx_overflow    = r_tx_overflow;
    assign prog_end       = (r_state == ST_HALT);

endmodule

// File: tb/tb_io_bus_bridge.sv
// Directed bench for io_bus_bridge: RAM path, TX FIFO, backpressure, counter snapshot, RX, stop sequence.
module tb_io_bus_bridge;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [31:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic        cpu_wr;
    logic [7:0]  cpu_din;
    logic        io_buffer_full;
    logic [16:0] ram_a;
    logic        ram_wr;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pop;
    logic        prog_end;
    logic        tx_overflow;

    logic [7:0]  w2_cpu_din;
    logic        w2_unused_full;
    logic [16:0] w2_unused_ram_a;
    logic        w2_unused_ram_wr;
    logic [7:0]  w2_unused_ram_dout;
    logic [7:0]  w2_unused_tx_data;
    logic        w2_unused_tx_valid;
    logic        w2_unused_rx_pop;
    logic        w2_unused_prog_end;
    logic        w2_unused_tx_overflow;

    int          n_run  = 0;
    int          n_fail = 0;
    logic [31:0] tb_cyc;
    logic [7:0]  ram_mem [0:131071];

    always #5 clk_in = ~clk_in;

    io_bus_bridge dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .cpu_a          (cpu_a),
        .cpu_dout       (cpu_dout),
        .cpu_wr         (cpu_wr),
        .cpu_din        (cpu_din),
        .io_buffer_full (io_buffer_full),
        .ram_a          (ram_a),
        .ram_wr         (ram_wr),
        .ram_dout       (ram_dout),
        .ram_din        (ram_din),
        .tx_data        (tx_data),
        .tx_valid       (tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_pop         (rx_pop),
        .prog_end       (prog_end),
        .tx_overflow    (tx_overflow)
    );

    io_bus_bridge #(.CNT_INIT(32'hFFFF_FF00)) dut_wrap (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .cpu_a          (cpu_a),
        .cpu_dout       (cpu_dout),
        .cpu_wr         (cpu_wr),
        .cpu_din        (w2_cpu_din),
        .io_buffer_full (w2_unused_full),
        .ram_a          (w2_unused_ram_a),
        .ram_wr         (w2_unused_ram_wr),
        .ram_dout       (w2_unused_ram_dout),
        .ram_din        (ram_din),
        .tx_data        (w2_unused_tx_data),
        .tx_valid       (w2_unused_tx_valid),
        .tx_ready       (tx_ready),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_pop         (w2_unused_rx_pop),
        .prog_end       (w2_unused_prog_end),
        .tx_overflow    (w2_unused_tx_overflow)
    );

    // External RAM with one-cycle read latency
    always @(posedge clk_in) begin
        if (ram_wr) ram_mem[ram_a] <= ram_dout;
        ram_din <= ram_mem[ram_a];
    end

    // Cycles since reset release: equals the counter value of a CNT_INIT=0 bridge
    always @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) tb_cyc <= 32'd0;
        else         tb_cyc <= tb_cyc + 32'd1;
    end

    task automatic cyc(input logic [31:0] a, input logic wr, input logic [7:0] d);
        @(negedge clk_in);
        cpu_a    = a;
        cpu_wr   = wr;
        cpu_dout = d;
        #1;
    endtask

    task automatic pulse_reset();
        @(negedge clk_in);
        rst_in = 1'b0;
        #2;
        rst_in = 1'b1;
    endtask

    task automatic test_reset();
        cpu_a = 32'h0001_0010; cpu_wr = 1'b1; cpu_dout = 8'hC3;
        #12;
        n_run++; if (ram_wr !== 1'b1) begin n_fail++; $display("FAIL rst_ram_wr: got %b want 1", ram_wr); end
        n_run++; if (ram_a !== 17'h10010) begin n_fail++; $display("FAIL rst_ram_a: got %h want 10010", ram_a); end
        n_run++; if (ram_dout !== 8'hC3) begin n_fail++; $display("FAIL rst_ram_dout: got %h want c3", ram_dout); end
        cpu_a = 32'h0003_0000; rx_valid = 1'b1; rx_data = 8'h11;
        #1;
        n_run++; if (ram_wr !== 1'b0) begin n_fail++; $display("FAIL rst_io_ram_wr: got %b want 0", ram_wr); end
        cpu_wr = 1'b0;
        #1;
        n_run++; if (rx_pop !== 1'b0) begin n_fail++; $display("FAIL rst_rx_pop: got %b want 0", rx_pop); end
        n_run++; if (cpu_din !== 8'h00) begin n_fail++; $display("FAIL rst_cpu_din: got %h want 00", cpu_din); end
        n_run++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid: got %b want 0", tx_valid); end
        n_run++; if (prog_end !== 1'b0) begin n_fail++; $display("FAIL rst_prog_end: got %b want 0", prog_end); end
        n_run++; if (tx_overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %b want 0", tx_overflow); end
        n_run++; if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b want 0", io_buffer_full); end
        @(negedge clk_in);
        cpu_a = 32'h0; cpu_wr = 1'b0; rx_valid = 1'b0;
        #2;
        rst_in = 1'b1;
    endtask

    task automatic test_ram();
        cyc(32'h0000_0010, 1'b1, 8'hA5);
        cyc(32'h0000_0020, 1'b1, 8'h5A);
        cyc(32'h0000_0010, 1'b0, 8'h00);
        n_run++; if (cpu_din !== 8'h00) begin n_fail++; $display("FAIL ram_early: got %h want 00", cpu_din); end
        cyc(32'h0000_0020, 1'b0, 8'h00);
        n_run++; if (cpu_din !== 8'hA5) begin n_fail++; $display("FAIL ram_rd10: got %h want a5", cpu_din); end
        cyc(32'h0000_0000, 1'b0, 8'h00);
        n_run++; if (cpu_din !== 8'h5A) begin n_fail++; $display("FAIL ram_rd20: got %h want 5a", cpu_din); end
    endtask

    task automatic test_tx();
        tx_ready = 1'b0;
        cyc(32'h0003_0000, 1'b1, 8'h48);
        cyc(32'h0003_0000, 1'b1, 8'h69);
        cyc(32'h0003_0000, 1'b1, 8'h00);
        cyc(32'h0, 1'b0, 8'h00);
        n_run++; if (tx_valid !== 1'b1 || tx_data !== 8'h48) begin n_fail++; $display("FAIL tx_head0: got v=%b d=%h want v=1 d=48", tx_valid, tx_data); end
        tx_ready = 1'b1;
        cyc(32'h0, 1'b0, 8'h00);
        n_run++; if (tx_valid !== 1'b1 || tx_data !== 8'h69) begin n_fail++; $display("FAIL tx_head1: got v=%b d=%h want v=1 d=69", tx_valid, tx_data); end
        cyc(32'h0, 1'b0, 8'h00);
        n_run++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL tx_no_zero: got v=%b want 0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [7:0] exp_q [16];
        tx_ready = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            cyc(32'h0003_0000, 1'b1, 8'(i));
            if (i == 14) begin
                n_run++; if (io_buffer_full !== 1'b0) begin n_fail++; $display("FAIL bp_full_at13: got %b want 0", io_buffer_full); end
            end
            if (i == 15) begin
                n_run++; if (io_buffer_full !== 1'b1) begin n_fail++; $display("FAIL bp_full_at14: got %b want 1", io_buffer_full); end
            end
        end
        cyc(32'h0003_0000, 1'b1, 8'h63);
        n_run++; if (tx_data !== 8'h01 || io_buffer_full !== 1'b1) begin n_fail++; $display("FAIL bp_at16: got d=%h full=%b want d=01 full=1", tx_data, io_buffer_full); end
        tx_ready = 1'b1;
        cyc(32'h0003_0000, 1'b1, 8'h77);
        tx_ready = 1'b0;
        n_run++; if (tx_overflow !== 1'b0 || tx_data !== 8'h02) begin n_fail++; $display("FAIL bp_pushpop_full: got ovf=%b d=%h want ovf=0 d=02", tx_overflow, tx_data); end
        cyc(32'h0, 1'b0, 8'h00);
        n_run++; if (tx_overflow !== 1'b1) begin n_fail++; $display("FAIL bp_overflow: got %b want 1", tx_overflow); end
        for (int k = 0; k < 15; k++) exp_q[k] = 8'(k + 2);
        exp_q[15] = 8'h63;
        tx_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            n_run++; if (tx_valid !== 1'b1 || tx_data !== exp_q[k]) begin n_fail++; $display("FAIL bp_drain[%0d]: got v=%b d=%h want v=1 d=%h", k, tx_valid, tx_data, exp_q[k]); end
            cyc(32'h0, 1'b0, 8'h00);
        end
        n_run++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got v=%b want 0", tx_valid); end
        tx_ready = 1'b0;
    endtask

    task automatic test_counter();
        logic [31:0] n;
        cyc(32'h0003_0004, 1'b0, 8'h00);
        n = tb_cyc;
        cyc(32'h0003_0005, 1'b0, 8'h00);
        n_run++; if (cpu_din !== n[7:0]) begin n_fail++; $display("FAIL cnt_b0: got %h want %h", cpu_din, n[7:0]); end
        cyc(32'h0003_0006, 1'b0, 8'h00);
        n_run++; if (cpu_din !== n[15:8]) begin n_fail++; $display("FAIL cnt_b1: got %h want %h", cpu_din, n[15:8]); end
        cyc(32'h0003_0007, 1'b0, 8'h00);
        n_run++; if (cpu_din !== n[23:16]) begin n_fail++; $display("FAIL cnt_b2: got %h want %h", cpu_din, n[23:16]); end
        cyc(32'h0, 1'b0, 8'h00);
        n_run++; if (cpu_din !== n[31:24]) begin n_fail++; $display("FAIL cnt_b3: got %h want %h", cpu_din, n[31:24]); end
    endtask

    task automatic test_rx();
        rx_data = 8'h37; rx_valid = 1'b1;
        cyc(32'h0003_0000, 1'b0, 8'h00);
        n_run++; if (rx_pop !== 1'b1) begin n_fail++; $display("FAIL rx_pop_hi: got %b want 1", rx_pop); end
        cyc(32'h0, 1'b0, 8'h00);
        rx_valid = 1'b0;
        #1;
        n_run++; if (rx_pop !== 1'b0) begin n_fail++; $display("FAIL rx_pop_lo: got %b want 0", rx_pop); end
        n_run++; if (cpu_din !== 8'h37) begin n_fail++; $display("FAIL rx_data: got %h want 37", cpu_din); end
        cyc(32'h0003_0000, 1'b0, 8'h00);
        n_run++; if (rx_pop !== 1'b0) begin n_fail++; $display("FAIL rx_nopop: got %b want 0", rx_pop); end
        cyc(32'h0000_0010, 1'b0, 8'h00);
        n_run++; if (cpu_din !== 8'h00) begin n_fail++; $display("FAIL rx_empty: got %h want 00", cpu_din); end
        cyc(32'h0003_0010, 1'b0, 8'h00);
        n_run++; if (cpu_din !== 8'hA5) begin n_fail++; $display("FAIL rx_ramrd: got %h want a5", cpu_din); end
        cyc(32'h0, 1'b0, 8'h00);
        n_run++; if (cpu_din !== 8'h00) begin n_fail++; $display("FAIL io_other: got %h want 00", cpu_din); end
    endtask

    task automatic test_stop();
        logic [7:0] exp_s [4];
        int         w;
        exp_s[0] = 8'h11; exp_s[1] = 8'h22; exp_s[2] = 8'h33; exp_s[3] = 8'h00;
        tx_ready = 1'b0;
        cyc(32'h0003_0000, 1'b1, 8'h11);
        cyc(32'h0003_0000, 1'b1, 8'h22);
        cyc(32'h0003_0000, 1'b1, 8'h33);
        cyc(32'h0003_0004, 1'b1, 8'h55);
        cyc(32'h0003_0000, 1'b1, 8'h44);
        cyc(32'h0, 1'b0, 8'h00);
        n_run++; if (prog_end !== 1'b0) begin n_fail++; $display("FAIL stop_early: got %b want 0", prog_end); end
        tx_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            n_run++; if (tx_valid !== 1'b1 || tx_data !== exp_s[k]) begin n_fail++; $display("FAIL stop_drain[%0d]: got v=%b d=%h want v=1 d=%h", k, tx_valid, tx_data, exp_s[k]); end
            cyc(32'h0, 1'b0, 8'h00);
        end
        w = 0;
        while (prog_end !== 1'b1 && w < 8) begin
            cyc(32'h0, 1'b0, 8'h00);
            w++;
        end
        n_run++; if (prog_end !== 1'b1 || tx_valid !== 1'b0) begin n_fail++; $display("FAIL stop_halt: got end=%b v=%b want end=1 v=0", prog_end, tx_valid); end
        cyc(32'h0003_0000, 1'b1, 8'h55);
        cyc(32'h0000_0010, 1'b0, 8'h00);
        cyc(32'h0, 1'b0, 8'h00);
        n_run++; if (tx_valid !== 1'b0 || prog_end !== 1'b1) begin n_fail++; $display("FAIL halt_ignore: got v=%b end=%b want v=0 end=1", tx_valid, prog_end); end
        n_run++; if (cpu_din !== 8'hA5) begin n_fail++; $display("FAIL halt_ramrd: got %h want a5", cpu_din); end
        tx_ready = 1'b0;
        pulse_reset();
        cyc(32'h0003_0000, 1'b1, 8'h21);
        cyc(32'h0003_0004, 1'b1, 8'h00);
        cyc(32'h0, 1'b0, 8'h00);
        cyc(32'h0, 1'b0, 8'h00);
        n_run++; if (tx_valid !== 1'b1 || prog_end !== 1'b0) begin n_fail++; $display("FAIL drain_hold: got v=%b end=%b want v=1 end=0", tx_valid, prog_end); end
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        n_run++; if (tx_valid !== 1'b0 || prog_end !== 1'b0 || tx_overflow !== 1'b0) begin n_fail++; $display("FAIL drain_reset: got v=%b end=%b ovf=%b want 0 0 0", tx_valid, prog_end, tx_overflow); end
        #1;
        rst_in = 1'b1;
        cyc(32'h0003_0000, 1'b1, 8'h5C);
        cyc(32'h0, 1'b0, 8'h00);
        n_run++; if (tx_valid !== 1'b1 || tx_data !== 8'h5C) begin n_fail++; $display("FAIL run_after_rst: got v=%b d=%h want v=1 d=5c", tx_valid, tx_data); end
    endtask

    task automatic test_wrap();
        logic [31:0] e1;
        logic [31:0] e2;
        pulse_reset();
        repeat (254) cyc(32'h0, 1'b0, 8'h00);
        cyc(32'h0003_0004, 1'b0, 8'h00);
        e1 = 32'hFFFF_FF00 + tb_cyc;
        cyc(32'h0003_0005, 1'b0, 8'h00);
        n_run++; if (w2_cpu_din !== e1[7:0]) begin n_fail++; $display("FAIL wrap_b0: got %h want %h", w2_cpu_din, e1[7:0]); end
        cyc(32'h0003_0006, 1'b0, 8'h00);
        n_run++; if (w2_cpu_din !== e1[15:8]) begin n_fail++; $display("FAIL wrap_b1: got %h want %h", w2_cpu_din, e1[15:8]); end
        cyc(32'h0003_0007, 1'b0, 8'h00);
        n_run++; if (w2_cpu_din !== e1[23:16]) begin n_fail++; $display("FAIL wrap_b2: got %h want %h", w2_cpu_din, e1[23:16]); end
        cyc(32'h0003_0004, 1'b0, 8'h00);
        e2 = 32'hFFFF_FF00 + tb_cyc;
        n_run++; if (w2_cpu_din !== e1[31:24]) begin n_fail++; $display("FAIL wrap_b3: got %h want %h", w2_cpu_din, e1[31:24]); end
        cyc(32'h0003_0005, 1'b0, 8'h00);
        n_run++; if (w2_cpu_din !== e2[7:0]) begin n_fail++; $display("FAIL wrap_after_b0: got %h want %h", w2_cpu_din, e2[7:0]); end
        cyc(32'h0, 1'b0, 8'h00);
        n_run++; if (w2_cpu_din !== e2[15:8]) begin n_fail++; $display("FAIL wrap_after_b1: got %h want %h", w2_cpu_din, e2[15:8]); end
    endtask

    initial begin
        rst_in   = 1'b0;
        cpu_a    = 32'h0;
        cpu_dout = 8'h00;
        cpu_wr   = 1'b0;
        tx_ready = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        test_reset();
        test_ram();
        test_tx();
        test_backpressure();
        test_counter();
        test_rx();
        test_stop();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
